// File: rtl/cdc_handshake_sender.sv
// rtl/cdc_handshake_sender.sv - 4-phase req/ack sending-side controller with ack synchronizer
//
// cdc_bit_synchronizer: SYNC_DEPTH = 2+EXTRA_DEPTH flop chain bringing one asynchronous
//   bit into receiving_clock. Stages reset to 0.
//   receiving_clock, receiving_reset_n (async, active-low), bit_in (async), bit_out.
//
// cdc_handshake_sender: accepts a word on data_in/data_valid/data_ready, holds it on
//   held_data and runs a 4-phase handshake (req up, ack up, req down, ack down).
//   sending_clock, sending_reset_n (async, active-low)
//   data_in, data_valid, data_ready   local word interface
//   held_data, req, ack_async         crossing interface
//   busy, done                        transfer status (done is a one-cycle pulse)
//   timeout_error, error_clear        sticky handshake timeout flag and its clear

module cdc_bit_synchronizer #(
  parameter int EXTRA_DEPTH = 0
) (
  input  logic receiving_clock,
  input  logic receiving_reset_n,
  input  logic bit_in,
  output logic bit_out
);

  localparam int SYNC_DEPTH = 2 + EXTRA_DEPTH;

  logic [SYNC_DEPTH-1:0] stages;

  always_ff @(posedge receiving_clock or negedge receiving_reset_n) begin
    if (!receiving_reset_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_DEPTH-2:0], bit_in};
    end
  end

  assign bit_out = stages[SYNC_DEPTH-1];

endmodule

module cdc_handshake_sender #(
  parameter int WIDTH          = 32,
  parameter int EXTRA_DEPTH    = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic             sending_clock,
  input  logic             sending_reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [WIDTH-1:0] held_data,
  output logic             req,
  input  logic             ack_async,
  output logic             busy,
  output logic             done,
  output logic             timeout_error,
  input  logic             error_clear
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic                     ack_sync;
  logic                     accept;
  logic [WIDTH-1:0]         held_data_next;
  logic                     req_next;
  logic                     busy_next;
  logic                     done_next;
  logic                     timeout_error_next;
  logic                     timeout_hit;
  logic [TIMEOUT_WIDTH-1:0] timeout_count, timeout_count_next;

  cdc_bit_synchronizer #(
    .EXTRA_DEPTH (EXTRA_DEPTH)
  ) u_ack_sync (
    .receiving_clock   (sending_clock),
    .receiving_reset_n (sending_reset_n),
    .bit_in            (ack_async),
    .bit_out           (ack_sync)
  );

  // A still-high ack left over from an interrupted transfer would complete the
  // next handshake at once, so no word is accepted until the receiver has let go.
  assign data_ready = (state == IDLE) && !ack_sync;
  assign accept     = data_valid && data_ready;

  always_ff @(posedge sending_clock or negedge sending_reset_n) begin
    if (!sending_reset_n) begin
      state         <= IDLE;
      held_data     <= '0;
      req           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_error <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_next;
      held_data     <= held_data_next;
      req           <= req_next;
      busy          <= busy_next;
      done          <= done_next;
      timeout_error <= timeout_error_next;
      timeout_count <= timeout_count_next;
    end
  end

  always_comb begin
    state_next     = state;
    held_data_next = held_data;
    req_next       = req;
    busy_next      = busy;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          held_data_next = data_in;
          req_next       = 1'b1;
          busy_next      = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_next   = 1'b0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // The counter stops at the limit so the flag fires once per wait phase; a
  // clear during a long wait is therefore not immediately undone.
  always_comb begin
    timeout_count_next = timeout_count;
    timeout_hit        = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      if (state_next != state) begin
        timeout_count_next = '0;
      end else if (state != IDLE) begin
        if (timeout_count != TIMEOUT_LIMIT) begin
          timeout_count_next = timeout_count + 1'b1;
        end
        if (timeout_count == TIMEOUT_LIMIT - 1'b1) begin
          timeout_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    timeout_error_next = timeout_error;
    if (timeout_hit) begin
      timeout_error_next = 1'b1;
    end else if (error_clear) begin
      timeout_error_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// tb/tb_cdc_handshake_sender.sv - randomized and directed bench for cdc_handshake_sender

module tb_cdc_handshake_sender;

  localparam int W          = 32;
  localparam int EXTRA      = 0;
  localparam int SYNC_D     = 2 + EXTRA;
  localparam int TMO        = 10;
  localparam int DEEP_EXTRA = 2;
  localparam int DEEP_SYNC  = 2 + DEEP_EXTRA;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic [W-1:0] held_data;
  logic         req;
  logic         ack_async;
  logic         busy;
  logic         done;
  logic         timeout_error;
  logic         error_clear;

  logic [W-1:0] d_data;
  logic         d_valid;
  logic         d_ready;
  logic [W-1:0] d_held;
  logic         d_req;
  logic         d_ack;
  logic         d_busy;
  logic         d_done;
  logic         d_err;
  logic         d_clear;

  always #5 clk = ~clk;

  cdc_handshake_sender #(
    .WIDTH (W), .EXTRA_DEPTH (EXTRA), .TIMEOUT_CYCLES (TMO), .TIMEOUT_WIDTH (16)
  ) u_dut (
    .sending_clock   (clk),
    .sending_reset_n (rst_n),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .held_data       (held_data),
    .req             (req),
    .ack_async       (ack_async),
    .busy            (busy),
    .done            (done),
    .timeout_error   (timeout_error),
    .error_clear     (error_clear)
  );

  cdc_handshake_sender #(
    .WIDTH (W), .EXTRA_DEPTH (DEEP_EXTRA), .TIMEOUT_CYCLES (0), .TIMEOUT_WIDTH (16)
  ) u_deep (
    .sending_clock   (clk),
    .sending_reset_n (rst_n),
    .data_in         (d_data),
    .data_valid      (d_valid),
    .data_ready      (d_ready),
    .held_data       (d_held),
    .req             (d_req),
    .ack_async       (d_ack),
    .busy            (d_busy),
    .done            (d_done),
    .timeout_error   (d_err),
    .error_clear     (d_clear)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: handshake phase (0 idle, 1 waiting for ack high, 2 waiting for
  // ack low), the ack as seen SYNC_D samples late, and cycles spent waiting.
  int           m_phase;
  logic [W-1:0] m_held;
  bit           m_done;
  bit           m_err;
  int           m_wait;
  bit           m_q[$];

  task automatic model_reset();
    m_phase = 0;
    m_held  = '0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_wait  = 0;
    m_q.delete();
    for (int i = 0; i < SYNC_D; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit s;
    int prev;
    bit hit;
    s      = m_q[0];
    prev   = m_phase;
    m_done = 1'b0;
    hit    = 1'b0;
    case (m_phase)
      0:       if (data_valid && !s) begin m_held = data_in; m_phase = 1; end
      1:       if (s) m_phase = 2;
      default: if (!s) begin m_phase = 0; m_done = 1'b1; end
    endcase
    if (m_phase != prev) begin
      m_wait = 0;
    end else if (m_phase != 0) begin
      m_wait++;
      hit = (m_wait == TMO);
    end
    if (hit) m_err = 1'b1;
    else if (error_clear) m_err = 1'b0;
    void'(m_q.pop_front());
    m_q.push_back(ack_async);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  int done_count = 0;

  always @(negedge clk) begin
    check_eq("m_req",   32'(req),           32'(m_phase == 1));
    check_eq("m_busy",  32'(busy),          32'(m_phase != 0));
    check_eq("m_done",  32'(done),          32'(m_done));
    check_eq("m_ready", 32'(data_ready),    32'(m_phase == 0 && !m_q[0]));
    check_eq("m_held",  held_data,          m_held);
    check_eq("m_err",   32'(timeout_error), 32'(m_err));
    if (done === 1'b1) done_count++;
  end

  task automatic wait_req(input logic lvl, output int edges);
    edges = 0;
    while (req !== lvl && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (req !== lvl) check_eq("wait_req_bound", 32'(req), 32'(lvl));
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit keep_valid);
    int n;
    n          = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (data_ready !== 1'b1) check_eq("send_bound", 32'(data_ready), 32'd1);
    @(negedge clk);
    if (!keep_valid) data_valid = 1'b0;
  endtask

  task automatic respond(input int rise_dly, input int fall_dly);
    int e;
    wait_req(1'b1, e);
    repeat (rise_dly) @(negedge clk);
    ack_async = 1'b1;
    wait_req(1'b0, e);
    repeat (fall_dly) @(negedge clk);
    ack_async = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (done !== 1'b1) check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int e;
    int dc0;
    logic [W-1:0] seen[3];

    rst_n = 1'b0; data_in = '0; data_valid = 1'b0; ack_async = 1'b0; error_clear = 1'b0;
    d_data = '0; d_valid = 1'b0; d_ack = 1'b0; d_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check_eq("rst_ready", 32'(data_ready),    32'd1);
    check_eq("rst_req",   32'(req),           32'd0);
    check_eq("rst_held",  held_data,          32'd0);
    check_eq("rst_busy",  32'(busy),          32'd0);
    check_eq("rst_done",  32'(done),          32'd0);
    check_eq("rst_err",   32'(timeout_error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // deeper synchronizer latency
    d_data  = 32'hA5A5_0F0F;
    d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    check_eq("deep_req_up", 32'(d_req), 32'd1);
    check_eq("deep_held",   d_held,     32'hA5A5_0F0F);
    d_ack = 1'b1;
    e = 0;
    while (d_req !== 1'b0 && e < 50) begin @(negedge clk); e++; end
    check_eq("deep_req_fall", 32'(e), 32'(DEEP_SYNC + 1));
    d_ack = 1'b0;
    e = 0;
    while (d_done !== 1'b1 && e < 50) begin @(negedge clk); e++; end
    check_eq("deep_done_lat", 32'(e), 32'(DEEP_SYNC + 1));
    @(negedge clk);
    check_eq("deep_done_pulse", 32'(d_done), 32'd0);
    check_eq("deep_busy_low",   32'(d_busy), 32'd0);

    // basic transfer
    dc0 = done_count;
    fork
      send_word(32'hDEAD_BEEF, 1'b0);
      begin
        int b;
        wait_req(1'b1, b);
        repeat (3) @(negedge clk);
        ack_async = 1'b1;
        wait_req(1'b0, b);
        check_eq("basic_req_fall", 32'(b), 32'(SYNC_D + 1));
        repeat (3) @(negedge clk);
        ack_async = 1'b0;
        wait_done("basic_done_bound", b);
        check_eq("basic_done_lat", 32'(b), 32'(SYNC_D + 1));
      end
    join
    repeat (2) @(negedge clk);
    check_eq("basic_held",  held_data,              32'hDEAD_BEEF);
    check_eq("basic_ndone", 32'(done_count - dc0),  32'd1);
    check_eq("basic_busy",  32'(busy),              32'd0);

    // back-to-back words with valid held
    dc0 = done_count;
    fork
      for (int i = 0; i < 3; i++) send_word(W'(i + 1), i < 2);
      for (int i = 0; i < 3; i++) begin
        int b;
        wait_req(1'b1, b);
        seen[i] = held_data;
        repeat (2) @(negedge clk);
        ack_async = 1'b1;
        wait_req(1'b0, b);
        @(negedge clk);
        ack_async = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) check_eq("b2b_held", seen[i], W'(i + 1));
    check_eq("b2b_ndone", 32'(done_count - dc0), 32'd3);

    // timeout with error_clear colliding on the setting edge
    send_word(32'h0BAD_F00D, 1'b0);
    repeat (9) @(negedge clk);
    check_eq("tmo_before", 32'(timeout_error), 32'd0);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check_eq("tmo_collide", 32'(timeout_error), 32'd1);
    check_eq("tmo_req_hold", 32'(req), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("tmo_sticky", 32'(timeout_error), 32'd1);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check_eq("tmo_cleared", 32'(timeout_error), 32'd0);
    dc0 = done_count;
    ack_async = 1'b1;
    wait_req(1'b0, e);
    ack_async = 1'b0;
    wait_done("tmo_done_bound", e);
    @(negedge clk);
    check_eq("tmo_late_done", 32'(done_count - dc0), 32'd1);

    // reset while in REQ with ack high
    send_word(32'h1234_5678, 1'b0);
    ack_async = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req",  32'(req), 32'd0);
    check_eq("mid_rst_held", held_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("stale_blocked", 32'(data_ready), 32'd0);
    ack_async = 1'b0;
    e = 0;
    while (data_ready !== 1'b1 && e < 50) begin @(negedge clk); e++; end
    check_eq("stale_release", 32'(e), 32'(SYNC_D));

    // randomized transfers checked by the reference
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      fork
        send_word($urandom, 1'($urandom_range(0, 1)));
        respond($urandom_range(0, 13), $urandom_range(0, 12));
        begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          error_clear = 1'b1;
          @(negedge clk);
          error_clear = 1'b0;
        end
      join
      data_valid = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
